// File: rtl/m_tlb_sa.sv
`default_nettype none
// ============================================================================
// Module   : m_tlb_sa
// Brief    : Set-associative Sv32 TLB with ASID/global tagging, a fully
//            associative megapage array and a sequential flush engine.
//            Optional hit/miss counters enabled by macro TLB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module m_tlb_sa #(
    parameter int WAYS         = 2,
    parameter int SETS         = 16,
    parameter int MEGA_ENTRIES = 4,
    parameter int ASID_W       = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [19:0]       w_lk_vpn,
    input  logic [ASID_W-1:0] w_lk_asid,
    output logic              w_lk_hit,
    output logic [21:0]       w_lk_ppn,
    output logic [7:0]        w_lk_flags,
    input  logic              w_we,
    input  logic [19:0]       w_wvpn,
    input  logic [ASID_W-1:0] w_wasid,
    input  logic [21:0]       w_wppn,
    input  logic [7:0]        w_wflags,
    input  logic              w_wmega,
    input  logic              w_flush_req,
    input  logic [1:0]        w_flush_mode,
    input  logic [19:0]       w_flush_vpn,
    input  logic [ASID_W-1:0] w_flush_asid,
    output logic              w_flush_busy,
    output logic [31:0]       w_perf_hits,
    output logic [31:0]       w_perf_miss
);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 20 - c_IDX_W;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_MEG_W = (MEGA_ENTRIES > 1) ? $clog2(MEGA_ENTRIES) : 1;
    localparam int c_G_BIT = 5;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DONE = 2'd2} t_state;
    t_state r_state, w_state_nxt;

    logic               r_v4    [SETS][WAYS];
    logic [c_TAG_W-1:0] r_tag4  [SETS][WAYS];
    logic [ASID_W-1:0]  r_asid4 [SETS][WAYS];
    logic [21:0]        r_ppn4  [SETS][WAYS];
    logic [7:0]         r_flg4  [SETS][WAYS];
    logic [c_WAY_W-1:0] r_rr4   [SETS];
    logic               r_vm    [MEGA_ENTRIES];
    logic [9:0]         r_tagm  [MEGA_ENTRIES];
    logic [ASID_W-1:0]  r_asidm [MEGA_ENTRIES];
    logic [11:0]        r_ppnm  [MEGA_ENTRIES];
    logic [7:0]         r_flgm  [MEGA_ENTRIES];
    logic [c_MEG_W-1:0] r_rrm;

    logic [1:0]         r_fl_mode;
    logic [19:0]        r_fl_vpn;
    logic [ASID_W-1:0]  r_fl_asid;
    logic [c_IDX_W-1:0] r_fl_idx;

    function automatic logic f_clr(input logic [1:0] mode, input logic tag_eq,
                                   input logic asid_eq, input logic g);
        case (mode)
            2'd0:    f_clr = 1'b1;
            2'd1:    f_clr = asid_eq && !g;
            2'd2:    f_clr = tag_eq;
            default: f_clr = tag_eq && asid_eq && !g;
        endcase
    endfunction

    // ---------------- lookup ----------------
    logic [c_IDX_W-1:0] w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_hit4, w_hitm;
    logic [21:0]        w_ppn4;
    logic [11:0]        w_ppnm;
    logic [7:0]         w_flg4, w_flgm;

    assign w_lk_idx     = w_lk_vpn[c_IDX_W-1:0];
    assign w_lk_tag     = w_lk_vpn[19:c_IDX_W];
    assign w_flush_busy = (r_state != S_IDLE);

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit4 = 1'b0; w_ppn4 = '0; w_flg4 = '0;
        w_hitm = 1'b0; w_ppnm = '0; w_flgm = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_v4[w_lk_idx][w] && (r_tag4[w_lk_idx][w] == w_lk_tag) &&
                (r_flg4[w_lk_idx][w][c_G_BIT] || (r_asid4[w_lk_idx][w] == w_lk_asid))) begin
                w_hit4 = 1'b1;
                w_ppn4 = r_ppn4[w_lk_idx][w];
                w_flg4 = r_flg4[w_lk_idx][w];
            end
        end
        for (int e = MEGA_ENTRIES - 1; e >= 0; e--) begin
            if (r_vm[e] && (r_tagm[e] == w_lk_vpn[19:10]) &&
                (r_flgm[e][c_G_BIT] || (r_asidm[e] == w_lk_asid))) begin
                w_hitm = 1'b1;
                w_ppnm = r_ppnm[e];
                w_flgm = r_flgm[e];
            end
        end
    end

    assign w_lk_hit   = !w_flush_busy && (w_hit4 || w_hitm);
    assign w_lk_ppn   = !w_lk_hit ? 22'd0 : (w_hit4 ? w_ppn4 : {w_ppnm, w_lk_vpn[9:0]});
    assign w_lk_flags = !w_lk_hit ? 8'd0  : (w_hit4 ? w_flg4 : w_flgm);

    // ---------------- fill victim selection ----------------
    logic               w_fl_acc, w_fill_ok;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_TAG_W-1:0] w_wr_tag;
    logic [c_WAY_W-1:0] w_vic4;
    logic [c_MEG_W-1:0] w_vicm;
    logic               w_use_rr4, w_use_rrm;

    assign w_fl_acc  = (r_state == S_IDLE) && w_flush_req;
    assign w_fill_ok = w_we && (r_state == S_IDLE) && !w_flush_req;
    assign w_wr_idx  = w_wvpn[c_IDX_W-1:0];
    assign w_wr_tag  = w_wvpn[19:c_IDX_W];

    // Priority: matching entry, then lowest invalid, then round-robin.
    always_comb begin
        w_vic4 = r_rr4[w_wr_idx]; w_use_rr4 = 1'b1;
        w_vicm = r_rrm;           w_use_rrm = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_v4[w_wr_idx][w]) begin
                w_vic4 = c_WAY_W'(w); w_use_rr4 = 1'b0;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_v4[w_wr_idx][w] && (r_tag4[w_wr_idx][w] == w_wr_tag) &&
                (r_flg4[w_wr_idx][w][c_G_BIT] || w_wflags[c_G_BIT] ||
                 (r_asid4[w_wr_idx][w] == w_wasid))) begin
                w_vic4 = c_WAY_W'(w); w_use_rr4 = 1'b0;
            end
        end
        for (int e = MEGA_ENTRIES - 1; e >= 0; e--) begin
            if (!r_vm[e]) begin
                w_vicm = c_MEG_W'(e); w_use_rrm = 1'b0;
            end
        end
        for (int e = MEGA_ENTRIES - 1; e >= 0; e--) begin
            if (r_vm[e] && (r_tagm[e] == w_wvpn[19:10]) &&
                (r_flgm[e][c_G_BIT] || w_wflags[c_G_BIT] || (r_asidm[e] == w_wasid))) begin
                w_vicm = c_MEG_W'(e); w_use_rrm = 1'b0;
            end
        end
    end

    // ---------------- flush engine ----------------
    logic [c_IDX_W-1:0] w_fl_set;
    logic               w_fl_mega, w_fl_last;
    logic               w_clr4 [WAYS];
    logic               w_clrm [MEGA_ENTRIES];

    assign w_fl_set  = r_fl_mode[1] ? r_fl_vpn[c_IDX_W-1:0] : r_fl_idx;
    assign w_fl_mega = r_fl_mode[1] || (r_fl_idx == '0);
    assign w_fl_last = r_fl_mode[1] || (r_fl_idx == c_IDX_W'(SETS - 1));

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_clr4[w] = f_clr(r_fl_mode, r_tag4[w_fl_set][w] == r_fl_vpn[19:c_IDX_W],
                              r_asid4[w_fl_set][w] == r_fl_asid, r_flg4[w_fl_set][w][c_G_BIT]);
        end
        for (int e = 0; e < MEGA_ENTRIES; e++) begin
            w_clrm[e] = f_clr(r_fl_mode, r_tagm[e] == r_fl_vpn[19:10],
                              r_asidm[e] == r_fl_asid, r_flgm[e][c_G_BIT]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_flush_req) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_fl_last)   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_fl_mode <= '0;
            r_fl_vpn  <= '0;
            r_fl_asid <= '0;
            r_fl_idx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fl_acc) begin
                r_fl_mode <= w_flush_mode;
                r_fl_vpn  <= w_flush_vpn;
                r_fl_asid <= w_flush_asid;
                r_fl_idx  <= '0;
            end else if (r_state == S_SWEEP && !w_fl_last) begin
                r_fl_idx <= r_fl_idx + 1'b1;
            end
        end
    end

    // Valid bits and replacement pointers: the only reset state of the arrays.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr4[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_v4[s][w] <= 1'b0;
            end
            for (int e = 0; e < MEGA_ENTRIES; e++) r_vm[e] <= 1'b0;
            r_rrm <= '0;
        end else if (w_fill_ok) begin
            if (w_wmega) begin
                r_vm[w_vicm] <= 1'b1;
                if (w_use_rrm)
                    r_rrm <= (r_rrm == c_MEG_W'(MEGA_ENTRIES - 1)) ? '0 : r_rrm + 1'b1;
            end else begin
                r_v4[w_wr_idx][w_vic4] <= 1'b1;
                if (w_use_rr4)
                    r_rr4[w_wr_idx] <= (r_rr4[w_wr_idx] == c_WAY_W'(WAYS - 1)) ? '0
                                                                             : r_rr4[w_wr_idx] + 1'b1;
            end
        end else if (r_state == S_SWEEP) begin
            for (int w = 0; w < WAYS; w++)
                if (w_clr4[w]) r_v4[w_fl_set][w] <= 1'b0;
            if (w_fl_mega)
                for (int e = 0; e < MEGA_ENTRIES; e++)
                    if (w_clrm[e]) r_vm[e] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill_ok) begin
            if (w_wmega) begin
                r_tagm[w_vicm]  <= w_wvpn[19:10];
                r_asidm[w_vicm] <= w_wasid;
                r_ppnm[w_vicm]  <= w_wppn[21:10];
                r_flgm[w_vicm]  <= w_wflags;
            end else begin
                r_tag4[w_wr_idx][w_vic4]  <= w_wr_tag;
                r_asid4[w_wr_idx][w_vic4] <= w_wasid;
                r_ppn4[w_wr_idx][w_vic4]  <= w_wppn;
                r_flg4[w_wr_idx][w_vic4]  <= w_wflags;
            end
        end
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] r_perf_hits, r_perf_miss;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_hits <= '0;
            r_perf_miss <= '0;
        end else if (w_fl_acc && (w_flush_mode == 2'd0)) begin
            r_perf_hits <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_lk_hit && (r_perf_hits != 32'hFFFF_FFFF))
                r_perf_hits <= r_perf_hits + 32'd1;
            if (!w_lk_hit && !w_flush_busy && !w_we && (r_perf_miss != 32'hFFFF_FFFF))
                r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign w_perf_hits = r_perf_hits;
    assign w_perf_miss = r_perf_miss;
`else
    assign w_perf_hits = 32'd0;
    assign w_perf_miss = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_tlb_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_tlb_sa
// Brief    : Directed self-checking bench for m_tlb_sa (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_tlb_sa;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [19:0] w_lk_vpn = '0;
    logic [8:0]  w_lk_asid = '0;
    logic        w_lk_hit;
    logic [21:0] w_lk_ppn;
    logic [7:0]  w_lk_flags;
    logic        w_we = 1'b0;
    logic [19:0] w_wvpn = '0;
    logic [8:0]  w_wasid = '0;
    logic [21:0] w_wppn = '0;
    logic [7:0]  w_wflags = '0;
    logic        w_wmega = 1'b0;
    logic        w_flush_req = 1'b0;
    logic [1:0]  w_flush_mode = '0;
    logic [19:0] w_flush_vpn = '0;
    logic [8:0]  w_flush_asid = '0;
    logic        w_flush_busy;
    logic [31:0] w_perf_hits, w_perf_miss;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    m_tlb_sa dut (
        .CLK(CLK), .RST(RST),
        .w_lk_vpn(w_lk_vpn), .w_lk_asid(w_lk_asid), .w_lk_hit(w_lk_hit),
        .w_lk_ppn(w_lk_ppn), .w_lk_flags(w_lk_flags),
        .w_we(w_we), .w_wvpn(w_wvpn), .w_wasid(w_wasid), .w_wppn(w_wppn),
        .w_wflags(w_wflags), .w_wmega(w_wmega),
        .w_flush_req(w_flush_req), .w_flush_mode(w_flush_mode),
        .w_flush_vpn(w_flush_vpn), .w_flush_asid(w_flush_asid),
        .w_flush_busy(w_flush_busy),
        .w_perf_hits(w_perf_hits), .w_perf_miss(w_perf_miss)
    );

    task automatic fill(input logic [19:0] vpn, input logic [8:0] asid,
                        input logic [21:0] ppn, input logic [7:0] flg, input logic mega);
        @(posedge CLK); #1;
        w_we = 1'b1; w_wvpn = vpn; w_wasid = asid; w_wppn = ppn; w_wflags = flg; w_wmega = mega;
        @(posedge CLK); #1;
        w_we = 1'b0; w_wmega = 1'b0;
    endtask

    task automatic look(input logic [19:0] vpn, input logic [8:0] asid);
        @(negedge CLK);
        w_lk_vpn = vpn; w_lk_asid = asid;
        #1;
    endtask

    // Issues one flush and returns the number of busy cycles and hits seen while busy.
    task automatic flush_run(input logic [1:0] mode, input logic [19:0] vpn,
                             input logic [8:0] asid, output int busy_cyc, output int hit_seen);
        @(posedge CLK); #1;
        w_flush_req = 1'b1; w_flush_mode = mode; w_flush_vpn = vpn; w_flush_asid = asid;
        @(posedge CLK); #1;
        w_flush_req = 1'b0;
        busy_cyc = 0; hit_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (w_flush_busy) begin
                busy_cyc++;
                if (w_lk_hit) hit_seen++;
            end else if (busy_cyc > 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        look(20'h12345, 9'd1);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL reset_hit got %0h want 0", w_lk_hit); else n_pass++;
        n_total++; if (w_lk_ppn !== 22'd0) $display("FAIL reset_ppn got %0h want 0", w_lk_ppn); else n_pass++;
        n_total++; if (w_lk_flags !== 8'd0) $display("FAIL reset_flags got %0h want 0", w_lk_flags); else n_pass++;
        n_total++; if (w_flush_busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", w_flush_busy); else n_pass++;
    endtask

    task automatic test_fill_lookup;
        fill(20'h12345, 9'd1, 22'h0ABCD, 8'hCF, 1'b0);
        look(20'h12345, 9'd1);
        n_total++; if (w_lk_hit !== 1'b1) $display("FAIL fill_hit got %0h want 1", w_lk_hit); else n_pass++;
        n_total++; if (w_lk_ppn !== 22'h0ABCD) $display("FAIL fill_ppn got %0h want 0abcd", w_lk_ppn); else n_pass++;
        n_total++; if (w_lk_flags !== 8'hCF) $display("FAIL fill_flags got %0h want cf", w_lk_flags); else n_pass++;
        look(20'h12345, 9'd2);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL asid_miss_hit got %0h want 0", w_lk_hit); else n_pass++;
        n_total++; if (w_lk_ppn !== 22'd0) $display("FAIL asid_miss_ppn got %0h want 0", w_lk_ppn); else n_pass++;
    endtask

    task automatic test_evict;
        int bc, hs;
        flush_run(2'd0, 20'd0, 9'd0, bc, hs);
        n_total++; if (bc != 17) $display("FAIL flush_all_busy got %0d want 17", bc); else n_pass++;
        fill(20'h00005, 9'd1, 22'h100, 8'h01, 1'b0);
        fill(20'h00015, 9'd1, 22'h101, 8'h01, 1'b0);
        fill(20'h00025, 9'd1, 22'h102, 8'h01, 1'b0);
        look(20'h00005, 9'd1);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL evict_v5 got %0h want 0", w_lk_hit); else n_pass++;
        look(20'h00015, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h101) $display("FAIL evict_v15 got %0h want 101", w_lk_ppn); else n_pass++;
        look(20'h00025, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h102) $display("FAIL evict_v25 got %0h want 102", w_lk_ppn); else n_pass++;
        fill(20'h00015, 9'd1, 22'h1FF, 8'h01, 1'b0);
        look(20'h00015, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h1FF) $display("FAIL inplace_v15 got %0h want 1ff", w_lk_ppn); else n_pass++;
        look(20'h00025, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h102) $display("FAIL inplace_v25 got %0h want 102", w_lk_ppn); else n_pass++;
        // Round-robin must still point at the way holding 0x00015.
        fill(20'h00035, 9'd1, 22'h103, 8'h01, 1'b0);
        look(20'h00015, 9'd1);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL rr_v15 got %0h want 0", w_lk_hit); else n_pass++;
        look(20'h00025, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h102) $display("FAIL rr_v25 got %0h want 102", w_lk_ppn); else n_pass++;
        look(20'h00035, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h103) $display("FAIL rr_v35 got %0h want 103", w_lk_ppn); else n_pass++;
    endtask

    task automatic test_mega;
        fill(20'h40000, 9'd1, 22'h0A8000, 8'h0F, 1'b1);
        look(20'h40123, 9'd1);
        n_total++; if (w_lk_hit !== 1'b1) $display("FAIL mega_hit got %0h want 1", w_lk_hit); else n_pass++;
        n_total++; if (w_lk_ppn !== 22'h0A8123) $display("FAIL mega_ppn got %0h want a8123", w_lk_ppn); else n_pass++;
        n_total++; if (w_lk_flags !== 8'h0F) $display("FAIL mega_flags got %0h want f", w_lk_flags); else n_pass++;
        look(20'h40523, 9'd1);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL mega_other_tag got %0h want 0", w_lk_hit); else n_pass++;
        fill(20'h40123, 9'd1, 22'h03333, 8'h07, 1'b0);
        look(20'h40123, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h03333) $display("FAIL prio_4k got %0h want 3333", w_lk_ppn); else n_pass++;
        look(20'h40124, 9'd1);
        n_total++; if (w_lk_ppn !== 22'h0A8124) $display("FAIL mega_other_set got %0h want a8124", w_lk_ppn); else n_pass++;
    endtask

    task automatic test_flush_asid;
        int bc, hs;
        fill(20'h0A000, 9'd5, 22'h777, 8'h21, 1'b0);
        fill(20'h0B001, 9'd3, 22'h888, 8'h01, 1'b0);
        fill(20'h0C002, 9'd4, 22'h999, 8'h01, 1'b0);
        look(20'h0A000, 9'd3);
        n_total++; if (w_lk_ppn !== 22'h777) $display("FAIL global_pre got %0h want 777", w_lk_ppn); else n_pass++;
        flush_run(2'd1, 20'd0, 9'd3, bc, hs);
        n_total++; if (bc != 17) $display("FAIL asid_busy got %0d want 17", bc); else n_pass++;
        n_total++; if (hs != 0) $display("FAIL busy_forced_miss got %0d want 0", hs); else n_pass++;
        look(20'h0A000, 9'd3);
        n_total++; if (w_lk_ppn !== 22'h777) $display("FAIL global_post got %0h want 777", w_lk_ppn); else n_pass++;
        look(20'h0B001, 9'd3);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL asid3_cleared got %0h want 0", w_lk_hit); else n_pass++;
        look(20'h0C002, 9'd4);
        n_total++; if (w_lk_ppn !== 22'h999) $display("FAIL asid4_kept got %0h want 999", w_lk_ppn); else n_pass++;
    endtask

    task automatic test_flush_va;
        int bc, hs;
        flush_run(2'd2, 20'h40123, 9'd0, bc, hs);
        n_total++; if (bc != 2) $display("FAIL va_busy got %0d want 2", bc); else n_pass++;
        look(20'h40123, 9'd1);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL va_cleared got %0h want 0", w_lk_hit); else n_pass++;
        look(20'h0C002, 9'd4);
        n_total++; if (w_lk_ppn !== 22'h999) $display("FAIL va_kept got %0h want 999", w_lk_ppn); else n_pass++;
        fill(20'h66666, 9'd6, 22'h123, 8'h01, 1'b0);
        flush_run(2'd3, 20'h66666, 9'd7, bc, hs);
        look(20'h66666, 9'd6);
        n_total++; if (w_lk_hit !== 1'b1) $display("FAIL vaasid_other_kept got %0h want 1", w_lk_hit); else n_pass++;
        flush_run(2'd3, 20'h66666, 9'd6, bc, hs);
        look(20'h66666, 9'd6);
        n_total++; if (w_lk_hit !== 1'b0) $display("FAIL vaasid_cleared got %0h want 0", w_lk_hit); else n_pass++;
    endtask

`ifdef TLB_PERF_CNT_EN
    task automatic test_perf;
        @(posedge CLK); #1;
        w_flush_req = 1'b1; w_flush_mode = 2'd0;
        @(posedge CLK); #1;
        w_flush_req = 1'b0;
        w_we = 1'b1; w_wvpn = 20'h01234; w_wasid = 9'd1; w_wppn = 22'h4321; w_wflags = 8'h01;
        w_lk_vpn = 20'h01234; w_lk_asid = 9'd1;
        @(negedge CLK);
        n_total++; if (w_perf_hits !== 32'd0) $display("FAIL perf_clr_hits got %0d want 0", w_perf_hits); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (!w_flush_busy) break;
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        w_we = 1'b0;
        repeat (10) @(posedge CLK);
        #1 w_lk_vpn = 20'h01235;
        repeat (3) @(posedge CLK);
        #1;
        n_total++; if (w_perf_hits !== 32'd10) $display("FAIL perf_hits got %0d want 10", w_perf_hits); else n_pass++;
        n_total++; if (w_perf_miss !== 32'd3) $display("FAIL perf_miss got %0d want 3", w_perf_miss); else n_pass++;
        w_flush_req = 1'b1; w_flush_mode = 2'd0;
        @(posedge CLK); #1;
        w_flush_req = 1'b0;
        @(negedge CLK);
        n_total++; if (w_perf_hits !== 32'd0) $display("FAIL perf_flush_hits got %0d want 0", w_perf_hits); else n_pass++;
        n_total++; if (w_perf_miss !== 32'd0) $display("FAIL perf_flush_miss got %0d want 0", w_perf_miss); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (!w_flush_busy) break;
            @(negedge CLK);
        end
    endtask
`else
    task automatic test_perf;
        @(negedge CLK);
        n_total++; if (w_perf_hits !== 32'd0) $display("FAIL perf_tie_hits got %0d want 0", w_perf_hits); else n_pass++;
        n_total++; if (w_perf_miss !== 32'd0) $display("FAIL perf_tie_miss got %0d want 0", w_perf_miss); else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_lookup();
        test_evict();
        test_mega();
        test_flush_asid();
        test_flush_va();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
